// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: run controller for serial pattern detection.
//
// A start command in IDLE latches a pattern of up to PAT_W bits, its length,
// a match target and a bit budget. The controller then scans the qualified
// serial stream, pulses match per detection and counts matches. A run ends
// when the target is reached (hit=1), when the budget is exhausted (hit=0),
// or on abort (no done pulse).
//
// Build option: define SEQ_SCAN_OVERLAP_EN to let successive matches share
// stream bits. Left undefined, each match needs pat_len fresh bits.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      run request, honoured only in IDLE
//   abort      cancel the current run (SCAN or DONE)
//   pattern    pattern bits; bit pat_len-1 is the first bit received
//   pat_len    pattern length, clamped to PAT_W
//   target     match count that ends the run, 0 = unlimited
//   max_bits   bit budget, 0 = unlimited
//   x_valid    x is valid this cycle
//   x          serial data bit
//   busy       run in progress (SCAN or DONE)
//   match      one-cycle pulse per detected match
//   match_cnt  matches in the current or last run (saturating)
//   done       one-cycle run-complete pulse
//   hit        valid with done: 1 = target reached, 0 = budget exhausted

module seq_scan_ctrl #(
   parameter int unsigned PAT_W = 4,
   parameter int unsigned LEN_W = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] pat_len,
   input  logic [CNT_W-1:0] target,
   input  logic [CNT_W-1:0] max_bits,
   input  logic             x_valid,
   input  logic             x,
   output logic             busy,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             done,
   output logic             hit
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e           state_q;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] hist_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] fill_q;
   logic [CNT_W-1:0] tgt_q;
   logic [CNT_W-1:0] max_q;
   logic [CNT_W-1:0] bit_cnt_q;

   logic [LEN_W-1:0] len_in;
   logic [PAT_W-1:0] hist_d;
   logic [LEN_W-1:0] fill_inc;
   logic [LEN_W-1:0] fill_d;
   logic [PAT_W-1:0] len_mask;
   logic             is_match;
   logic [CNT_W-1:0] bit_cnt_d;
   logic [CNT_W-1:0] match_cnt_d;
   logic             term_hit;
   logic             term_budget;

   // Next-state values for one accepted sample in SCAN.
   always_comb begin
      len_in = (pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : pat_len;

      hist_d   = {hist_q[PAT_W-2:0], x};
      fill_inc = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;

      len_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         len_mask[i] = (i < int'(len_q));
      end

      // Only the low len bits of history and pattern take part.
      is_match = (fill_inc >= len_q) && (((hist_d ^ pat_q) & len_mask) == '0);

`ifdef SEQ_SCAN_OVERLAP_EN
      fill_d = fill_inc;
`else
      fill_d = is_match ? '0 : fill_inc;
`endif

      bit_cnt_d   = (&bit_cnt_q) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
      match_cnt_d = (is_match && !(&match_cnt)) ? match_cnt + CNT_W'(1) : match_cnt;

      term_hit    = (tgt_q != '0) && (match_cnt_d == tgt_q);
      term_budget = (max_q != '0) && (bit_cnt_d == max_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         pat_q     <= '0;
         hist_q    <= '0;
         len_q     <= '0;
         fill_q    <= '0;
         tgt_q     <= '0;
         max_q     <= '0;
         bit_cnt_q <= '0;
         busy      <= 1'b0;
         match     <= 1'b0;
         match_cnt <= '0;
         done      <= 1'b0;
         hit       <= 1'b0;
      end else begin
         match <= 1'b0;
         done  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  pat_q     <= pattern;
                  len_q     <= len_in;
                  tgt_q     <= target;
                  max_q     <= max_bits;
                  hist_q    <= '0;
                  fill_q    <= '0;
                  bit_cnt_q <= '0;
                  match_cnt <= '0;
                  hit       <= 1'b0;
                  busy      <= 1'b1;
                  if (len_in == '0) begin
                     // Empty pattern: complete immediately without a hit.
                     state_q <= StDone;
                     done    <= 1'b1;
                  end else begin
                     state_q <= StScan;
                  end
               end
            end
            StScan: begin
               if (abort) begin
                  // Abort wins over a terminal sample; the sample is dropped.
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end else if (x_valid) begin
                  hist_q    <= hist_d;
                  fill_q    <= fill_d;
                  bit_cnt_q <= bit_cnt_d;
                  match     <= is_match;
                  match_cnt <= match_cnt_d;
                  if (term_hit || term_budget) begin
                     state_q <= StDone;
                     done    <= 1'b1;
                     hit     <= term_hit;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: a per-cycle vector table for the
// main runs, plus hand-written sequences for reset, gaps, aborts and edges.

module tb_seq_scan_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic       abort;
   logic [3:0] pattern;
   logic [2:0] pat_len;
   logic [7:0] target;
   logic [7:0] max_bits;
   logic       x_valid;
   logic       x;
   logic       busy;
   logic       match;
   logic [7:0] match_cnt;
   logic       done;
   logic       hit;

   int total = 0;
   int bad   = 0;

   seq_scan_ctrl #(
      .PAT_W(4),
      .LEN_W(3),
      .CNT_W(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .pattern  (pattern),
      .pat_len  (pat_len),
      .target   (target),
      .max_bits (max_bits),
      .x_valid  (x_valid),
      .x        (x),
      .busy     (busy),
      .match    (match),
      .match_cnt(match_cnt),
      .done     (done),
      .hit      (hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       st;
      logic       ab;
      logic       xv;
      logic       xb;
      logic [3:0] pat;
      logic [2:0] len;
      logic [7:0] tgt;
      logic [7:0] mx;
      logic       e_busy;
      logic       e_match;
      logic [7:0] e_cnt;
      logic       e_done;
      logic       e_hit;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic st, input logic ab, input logic xv, input logic xb,
                               input logic [3:0] pat, input logic [2:0] len,
                               input logic [7:0] tgt, input logic [7:0] mx,
                               input logic e_busy, input logic e_match, input logic [7:0] e_cnt,
                               input logic e_done, input logic e_hit);
      vec_t v;
      v.st = st; v.ab = ab; v.xv = xv; v.xb = xb;
      v.pat = pat; v.len = len; v.tgt = tgt; v.mx = mx;
      v.e_busy = e_busy; v.e_match = e_match; v.e_cnt = e_cnt;
      v.e_done = e_done; v.e_hit = e_hit;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic cfg(input logic [3:0] pat, input logic [2:0] len,
                      input logic [7:0] tgt, input logic [7:0] mx);
      pattern = pat; pat_len = len; target = tgt; max_bits = mx;
   endtask

   // Drive one cycle of control inputs, then sample 1 time unit after the edge.
   task automatic step(input logic st, input logic ab, input logic xv, input logic xb);
      start = st; abort = ab; x_valid = xv; x = xb;
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0; x_valid = 1'b0; x = 1'b0;
   endtask

   task automatic chk_all(input string tag, input logic e_busy, input logic e_match,
                          input logic [7:0] e_cnt, input logic e_done, input logic e_hit);
      chk({tag, " busy"}, 32'(busy), 32'(e_busy));
      chk({tag, " match"}, 32'(match), 32'(e_match));
      chk({tag, " match_cnt"}, 32'(match_cnt), 32'(e_cnt));
      chk({tag, " done"}, 32'(done), 32'(e_done));
      chk({tag, " hit"}, 32'(hit), 32'(e_hit));
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0; abort = 1'b0; x_valid = 1'b0; x = 1'b0;
      cfg(4'b0000, 3'd0, 8'd0, 8'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      rst = 1'b1;
      step(0, 0, 0, 0);
      chk_all("post_reset", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

      // Run A: pattern 1011, len 4, target 2, unlimited budget, stream 1011011.
      add(1, 0, 0, 0, 4'b1011, 3'd4, 8'd2, 8'd0, 1, 0, 8'd0, 0, 0);
      add(0, 0, 1, 1, 4'b1011, 3'd4, 8'd2, 8'd0, 1, 0, 8'd0, 0, 0);
      add(0, 0, 1, 0, 4'b1011, 3'd4, 8'd2, 8'd0, 1, 0, 8'd0, 0, 0);
      add(0, 0, 1, 1, 4'b1011, 3'd4, 8'd2, 8'd0, 1, 0, 8'd0, 0, 0);
      add(0, 0, 1, 1, 4'b1011, 3'd4, 8'd2, 8'd0, 1, 1, 8'd1, 0, 0);
      add(0, 0, 1, 0, 4'b1011, 3'd4, 8'd2, 8'd0, 1, 0, 8'd1, 0, 0);
      add(0, 0, 1, 1, 4'b1011, 3'd4, 8'd2, 8'd0, 1, 0, 8'd1, 0, 0);
`ifdef SEQ_SCAN_OVERLAP_EN
      add(0, 0, 1, 1, 4'b1011, 3'd4, 8'd2, 8'd0, 1, 1, 8'd2, 1, 1);
      add(0, 1, 0, 0, 4'b1011, 3'd4, 8'd2, 8'd0, 0, 0, 8'd2, 0, 1);
`else
      add(0, 0, 1, 1, 4'b1011, 3'd4, 8'd2, 8'd0, 1, 0, 8'd1, 0, 0);
      add(0, 1, 0, 0, 4'b1011, 3'd4, 8'd2, 8'd0, 0, 0, 8'd1, 0, 0);
`endif
      // Run B: pattern 110, len 3, target 5, budget 6, stream 000000.
      add(1, 0, 0, 0, 4'b0110, 3'd3, 8'd5, 8'd6, 1, 0, 8'd0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         add(0, 0, 1, 0, 4'b0110, 3'd3, 8'd5, 8'd6, 1, 0, 8'd0, 0, 0);
      end
      add(0, 0, 1, 0, 4'b0110, 3'd3, 8'd5, 8'd6, 1, 0, 8'd0, 1, 0);
      add(0, 0, 0, 0, 4'b0110, 3'd3, 8'd5, 8'd6, 0, 0, 8'd0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         cfg(vecs[i].pat, vecs[i].len, vecs[i].tgt, vecs[i].mx);
         step(vecs[i].st, vecs[i].ab, vecs[i].xv, vecs[i].xb);
         chk_all($sformatf("row%0d", i), vecs[i].e_busy, vecs[i].e_match, vecs[i].e_cnt,
                 vecs[i].e_done, vecs[i].e_hit);
      end

      // Reset asserted mid-run clears everything immediately.
      cfg(4'b0011, 3'd2, 8'd0, 8'd0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      chk_all("pre_rst", 1'b1, 1'b1, 8'd1, 1'b0, 1'b0);
      rst = 1'b0;
      #2;
      chk_all("mid_rst", 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step(0, 0, 0, 0);
      chk("after_rst busy", 32'(busy), 32'd0);

      // Gaps in x_valid do not advance the bit budget.
      cfg(4'b1011, 3'd4, 8'd0, 8'd4);
      step(1, 0, 0, 0);
      step(0, 0, 1, 1);
      chk("gap b1 match", 32'(match), 32'd0);
      step(0, 0, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("gap idle done", 32'(done), 32'd0);
      step(0, 0, 1, 1);
      chk("gap b3 match", 32'(match), 32'd0);
      step(0, 0, 0, 0);
      chk("gap idle busy", 32'(busy), 32'd1);
      step(0, 0, 1, 1);
      chk_all("gap b4", 1'b1, 1'b1, 8'd1, 1'b1, 1'b0);
      step(0, 0, 0, 0);
      chk("gap end busy", 32'(busy), 32'd0);

      // Target and budget reached on the same sample: hit wins.
      cfg(4'b1111, 3'd4, 8'd1, 8'd4);
      step(1, 0, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      chk("same b3 done", 32'(done), 32'd0);
      step(0, 0, 1, 1);
      chk_all("same b4", 1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
      step(0, 0, 0, 0);

      // Over-long pat_len clamps to 4.
      cfg(4'b1111, 3'd7, 8'd1, 8'd0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      chk("clamp b3 match", 32'(match), 32'd0);
      step(0, 0, 1, 1);
      chk_all("clamp b4", 1'b1, 1'b1, 8'd1, 1'b1, 1'b1);
      step(0, 0, 0, 0);

      // Abort together with a terminal sample: no done, back to IDLE.
      cfg(4'b0011, 3'd2, 8'd1, 8'd0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 1);
      step(0, 1, 1, 1);
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk("abort match", 32'(match), 32'd0);
      step(0, 0, 0, 0);
      chk("abort later done", 32'(done), 32'd0);

      // pat_len 0: one-cycle run; a start during DONE is ignored.
      cfg(4'b0000, 3'd0, 8'd0, 8'd0);
      step(1, 0, 0, 0);
      chk_all("len0", 1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
      step(1, 0, 0, 0);
      chk("start_in_done busy", 32'(busy), 32'd0);
      chk("start_in_done done", 32'(done), 32'd0);
      step(1, 0, 0, 0);
      chk("b2b busy", 32'(busy), 32'd1);
      chk("b2b done", 32'(done), 32'd1);
      step(0, 0, 0, 0);
      chk("b2b end busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
